// File: rtl/thermo_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | thermo_decoder_if : thermometer-in / binary-out bus for thermo_decoder     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface thermo_decoder_if #(
    parameter int WIDTH   = 15,
    parameter int COUNT_W = 4,
    parameter int ERR_W   = 8
);
    logic               in_valid;
    logic [WIDTH-1:0]   thermo;
    logic               out_valid;
    logic [COUNT_W-1:0] count;
    logic               bubble_err;
    logic               stable;
    logic [ERR_W-1:0]   err_count;

    modport master (
        output in_valid, thermo,
        input  out_valid, count, bubble_err, stable, err_count
    );

    modport slave (
        input  in_valid, thermo,
        output out_valid, count, bubble_err, stable, err_count
    );
endinterface
`default_nettype wire

// File: rtl/thermo_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | thermo_decoder : 2-stage thermometer-to-binary decoder with bubble,        |
// | stability and error tracking. THERMO_BUBBLE_FIX_EN selects popcount decode.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module thermo_decoder #(
    parameter int WIDTH    = 15,
    parameter int COUNT_W  = 4,
    parameter int STABLE_N = 4,
    parameter int ERR_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    thermo_decoder_if.slave bus
);
    localparam logic [3:0]       C_STABLE_N = 4'(STABLE_N);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = '1;

    logic [WIDTH-1:0]   r_thermo1;
    logic               r_bubble1;
    logic               r_v1;

    logic [COUNT_W-1:0] r_count;
    logic               r_bubble_err;
    logic               r_out_valid;
    logic               r_stable;
    logic [3:0]         r_sc;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_bubble;
    logic [COUNT_W-1:0] w_count;
    logic [3:0]         w_sc_nxt;

    // A bubble is any 1 sitting directly above a 0.
    assign w_bubble = |(bus.thermo[WIDTH-1:1] & ~bus.thermo[WIDTH-2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thermo1 <= '0;
            r_bubble1 <= 1'b0;
            r_v1      <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_thermo1 <= bus.thermo;
                r_bubble1 <= w_bubble;
            end
        end
    end

`ifdef THERMO_BUBBLE_FIX_EN
    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + COUNT_W'(r_thermo1[i]);
        end
    end
`else
    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_thermo1[i]) begin
                w_count = COUNT_W'(i + 1);
            end
        end
    end
`endif

    // sc == 0 only right after reset, so it marks "no previous valid count".
    always_comb begin
        w_sc_nxt = r_sc;
        if ((r_sc == 4'd0) || (w_count != r_count)) begin
            w_sc_nxt = 4'd1;
        end else if (r_sc < C_STABLE_N) begin
            w_sc_nxt = r_sc + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_count      <= '0;
            r_bubble_err <= 1'b0;
            r_sc         <= 4'd0;
            r_stable     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_count      <= w_count;
                r_bubble_err <= r_bubble1;
                r_sc         <= w_sc_nxt;
                r_stable     <= (w_sc_nxt == C_STABLE_N);
                if (r_bubble1 && (r_err_count != C_ERR_MAX)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.count      = r_count;
    assign bus.bubble_err = r_bubble_err;
    assign bus.stable     = r_stable;
    assign bus.err_count  = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_thermo_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_thermo_decoder : scoreboard bench for thermo_decoder                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_thermo_decoder;
    localparam int STABLE_N = 4;

`ifdef THERMO_BUBBLE_FIX_EN
    localparam logic [3:0] BUB_CNT = 4'd4;
`else
    localparam logic [3:0] BUB_CNT = 4'd5;
`endif
    localparam logic [14:0] BUB_CODE = 15'b000_0000_0001_0111;

    typedef struct {
        logic [3:0] c;
        logic       b;
        logic       s;
        logic [7:0] e;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    exp_t q[$];
    exp_t e;

    // Reference model state, updated as stimulus is issued
    int         m_sc = 0;
    logic [3:0] m_last = '0;
    int         m_err = 0;

    logic [3:0] last_c = '0;
    logic       last_s = 1'b0;
    logic [7:0] last_e = '0;

    thermo_decoder_if #(.WIDTH(15), .COUNT_W(4), .ERR_W(8)) u_if ();

    thermo_decoder #(
        .WIDTH(15), .COUNT_W(4), .STABLE_N(STABLE_N), .ERR_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst_q) begin
            vectors++;
            if (u_if.out_valid) begin
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: count=%0d at cycle %0d, none expected",
                             u_if.count, cyc);
                end else begin
                    e = q.pop_front();
                    if (u_if.count !== e.c || u_if.bubble_err !== e.b ||
                        u_if.stable !== e.s || u_if.err_count !== e.e || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL output: got count=%0d bub=%0b stable=%0b err=%0d cyc=%0d, want count=%0d bub=%0b stable=%0b err=%0d cyc=%0d",
                                 u_if.count, u_if.bubble_err, u_if.stable, u_if.err_count, cyc,
                                 e.c, e.b, e.s, e.e, e.cyc);
                    end
                    last_c = e.c;
                    last_s = e.s;
                    last_e = e.e;
                end
            end else if (u_if.count !== last_c || u_if.stable !== last_s ||
                         u_if.err_count !== last_e) begin
                miscompares++;
                $display("FAIL hold: got count=%0d stable=%0b err=%0d, want count=%0d stable=%0b err=%0d",
                         u_if.count, u_if.stable, u_if.err_count, last_c, last_s, last_e);
            end
        end
    end

    task automatic send(input logic [14:0] code, input logic [3:0] ec, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b1;
        u_if.thermo   = code;
        if (m_sc == 0 || ec != m_last) m_sc = 1;
        else if (m_sc < STABLE_N) m_sc = m_sc + 1;
        m_last = ec;
        if (eb && m_err != 255) m_err = m_err + 1;
        x.c   = ec;
        x.b   = eb;
        x.s   = (m_sc == STABLE_N);
        x.e   = 8'(m_err);
        x.cyc = cyc + 2;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            u_if.in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        vectors++;
        if (u_if.out_valid !== 1'b0 || u_if.count !== 4'd0 || u_if.bubble_err !== 1'b0 ||
            u_if.stable !== 1'b0 || u_if.err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL %s: got ov=%0b count=%0d bub=%0b stable=%0b err=%0d, want all zero",
                     tag, u_if.out_valid, u_if.count, u_if.bubble_err, u_if.stable, u_if.err_count);
        end
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.thermo   = '0;

        // Power-on reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_state");
        rst = 1'b0;

        // Sweep every legal code 0..15
        for (int n = 0; n <= 15; n++) begin
            logic [15:0] code;
            code = (16'd1 << n) - 16'd1;
            send(code[14:0], 4'(n), 1'b0);
        end
        idle(3);

        // Bubble sample
        send(BUB_CODE, BUB_CNT, 1'b1);
        idle(2);

        // Stability: code 7 five times, then code 8
        repeat (5) send(15'h007F, 4'd7, 1'b0);
        send(15'h00FF, 4'd8, 1'b0);
        idle(2);

        // Gaps: code 3 with in_valid alternating
        repeat (5) begin
            send(15'h0007, 4'd3, 1'b0);
            idle(1);
        end
        idle(2);

        // Reset mid-stream with in_valid held high
        send(15'h0001, 4'd1, 1'b0);
        send(15'h0003, 4'd2, 1'b0);
        send(15'h0007, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.thermo   = 15'h003F;
        m_sc = 0; m_last = '0; m_err = 0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        last_c = '0; last_s = 1'b0; last_e = '0;
        check_reset_state("mid_reset");
        rst = 1'b0;
        u_if.in_valid = 1'b0;
        idle(4);
        send(15'h0003, 4'd2, 1'b0);
        send(15'h0003, 4'd2, 1'b0);
        idle(2);

        // Error counter saturation
        repeat (260) send(BUB_CODE, BUB_CNT, 1'b1);
        idle(1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d outputs still outstanding, want 0", q.size());
        end
        vectors++;
        if (u_if.err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL saturation: err_count=%0d, want 255", u_if.err_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
